tt_proj_sel: RTL and testbench

- Mux-side counterpart of the per-project wrappers: selects one of N_PROJ projects and drives the shared 18-bit project input bus.
- Gates each project's ena.
- Muxes the selected project's 24-bit output word back to the pads.
- Selection is stepped by external inc/clear pins, with break-before-make switching and project reset held during the switch.

---
 rtl/tt_proj_sel.sv | 73 +++++++
 tb/tb_tt_proj_sel.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tt_proj_sel.sv
// tt_proj_sel: project selector with break-before-make enable switching and registered output mux
module tt_proj_sel #(
  parameter int N_PROJ = 16,
  parameter int ADDR_W = 4,
  parameter int GUARD  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sel_inc,
  input  logic                   sel_clr,
  input  logic                   pad_rst_n,
  input  logic [7:0]             ui_in,
  input  logic [7:0]             uio_in,
  input  logic [N_PROJ*24-1:0]   ow_all,
  output logic [17:0]            iw,
  output logic [N_PROJ-1:0]      ena,
  output logic [7:0]             uo_out,
  output logic [7:0]             uio_out,
  output logic [7:0]             uio_oe,
  output logic [ADDR_W-1:0]      cur_addr,
  output logic                   busy
);
  localparam logic [0:0] SWITCH = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;
  localparam int CW = $clog2(GUARD) + 1;
  logic [2:0] inc_s, clr_s;
  logic inc_ev, clr_ev, ev, proj_rst_n;
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] addr, nxt_addr;
  logic [23:0] sel_w;
  // Synchronizers keep sampling through reset so a pin held high never looks like a fresh edge.
  always_ff @(posedge clk) begin
    inc_s <= {inc_s[1:0], sel_inc};
    clr_s <= {clr_s[1:0], sel_clr};
  end
  always_comb begin
    ev = inc_ev | clr_ev;
    nxt_addr = clr_ev ? '0 : (addr == ADDR_W'(N_PROJ - 1)) ? '0 : addr + 1'b1;
    sel_w = ow_all[addr*24 +: 24];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inc_ev <= 1'b0;
      clr_ev <= 1'b0;
      state <= SWITCH;
      cnt <= '0;
      addr <= '0;
      ena <= '0;
      {uio_oe, uio_out, uo_out} <= '0;
    end else begin
      inc_ev <= inc_s[1] & ~inc_s[2];
      clr_ev <= clr_s[1] & ~clr_s[2];
      {uio_oe, uio_out, uo_out} <= (state == ACTIVE) ? sel_w : '0;
      if (ev) begin
        state <= SWITCH;
        cnt <= '0;
        addr <= nxt_addr;
        ena <= '0;
      end else if (state == SWITCH) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(GUARD - 1)) begin
          state <= ACTIVE;
          ena <= N_PROJ'(1) << addr;
        end
      end
    end
  end
  assign proj_rst_n = pad_rst_n & (state == ACTIVE);
  assign iw = {uio_in, ui_in, proj_rst_n, clk};
  assign cur_addr = addr;
  assign busy = (state == SWITCH);
endmodule

// File: tb/tb_tt_proj_sel.sv
// tb_tt_proj_sel: directed vector table plus hand sequences for guard timing, double events and reset
module tb_tt_proj_sel;
  logic clk = 0, rst_n, sel_inc, sel_clr, pad_rst_n;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic [16*24-1:0] ow_all;
  logic [17:0] iw;
  logic [15:0] ena;
  logic [3:0] cur_addr;
  logic busy;
  int checks = 0, errors = 0, busy_cnt = 0;
  bit mon_en = 0;
  logic prev_rstn = 0, prev_busy = 1;
  logic [3:0] prev_addr = 0;

  tt_proj_sel #(.N_PROJ(16), .ADDR_W(4), .GUARD(4)) dut (
    .clk(clk), .rst_n(rst_n), .sel_inc(sel_inc), .sel_clr(sel_clr),
    .pad_rst_n(pad_rst_n), .ui_in(ui_in), .uio_in(uio_in), .ow_all(ow_all),
    .iw(iw), .ena(ena), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
    .cur_addr(cur_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] slot(input int k);
    return {8'(8'h90 + k), 8'(8'h50 + k), 8'(8'h10 + k)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
  endtask

  task automatic pulse(input bit i, input bit c);
    sel_inc = i;
    sel_clr = c;
    tick;
    sel_inc = 0;
    sel_clr = 0;
    repeat (9) tick;
  endtask

  // Invariant monitor: enables, project reset, bus wiring and 1-cycle registered output mux
  always @(negedge clk) begin
    logic [23:0] exp_o;
    if (mon_en) begin
      exp_o = (!prev_rstn || prev_busy) ? 24'h0 : slot(int'(prev_addr));
      chk("mon_out", {8'h0, uio_oe, uio_out, uo_out}, {8'h0, exp_o});
      chk("mon_ena", {16'h0, ena}, busy ? 32'h0 : (32'h1 << cur_addr));
      chk("mon_iw", {15'h0, iw[17:1]}, {15'h0, uio_in, ui_in, ~busy & pad_rst_n});
      if (!prev_rstn) chk("mon_rst", {27'h0, busy, cur_addr}, {27'h0, 1'b1, 4'h0});
    end
    prev_rstn = rst_n;
    prev_busy = busy;
    prev_addr = cur_addr;
  end

  typedef struct {
    int n_inc;
    bit both;
    bit clr;
    logic [3:0] exp_addr;
  } vec_t;
  vec_t vecs[11];

  initial begin
    int w, n;
    vecs[0]  = '{1, 0, 0, 4'd1};
    vecs[1]  = '{1, 0, 0, 4'd2};
    vecs[2]  = '{1, 0, 0, 4'd3};
    vecs[3]  = '{2, 0, 0, 4'd5};
    vecs[4]  = '{0, 1, 0, 4'd0};
    vecs[5]  = '{15, 0, 0, 4'd15};
    vecs[6]  = '{1, 0, 0, 4'd0};
    vecs[7]  = '{3, 0, 0, 4'd3};
    vecs[8]  = '{0, 0, 1, 4'd0};
    vecs[9]  = '{0, 0, 1, 4'd0};
    vecs[10] = '{6, 0, 0, 4'd6};
    for (int k = 0; k < 16; k++) ow_all[k*24 +: 24] = slot(k);
    rst_n = 0; sel_inc = 0; sel_clr = 0; pad_rst_n = 1; ui_in = 8'h3C; uio_in = 8'hC3;
    repeat (4) tick;
    mon_en = 1;
    tick;
    chk("rst_busy", {31'h0, busy}, 32'h1);
    chk("rst_ena", {16'h0, ena}, 32'h0);
    chk("rst_addr", {28'h0, cur_addr}, 32'h0);
    chk("rst_out", {8'h0, uio_oe, uio_out, uo_out}, 32'h0);
    rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      tick;
      chk("guard_busy", {31'h0, busy}, 32'h1);
      chk("guard_prst", {31'h0, iw[1]}, 32'h0);
    end
    tick;
    chk("act_busy", {31'h0, busy}, 32'h0);
    chk("act_ena", {16'h0, ena}, 32'h1);
    chk("act_uo_lat", {24'h0, uo_out}, 32'h0);
    chk("act_prst", {31'h0, iw[1]}, 32'h1);
    tick;
    chk("act_uo", {24'h0, uo_out}, 32'h10);
    chk("act_oe", {24'h0, uio_oe}, 32'h90);
    pad_rst_n = 0; ui_in = 8'hA5;
    #1;
    chk("pad_rst", {31'h0, iw[1]}, 32'h0);
    chk("iw_ui", {24'h0, iw[9:2]}, 32'hA5);
    pad_rst_n = 1;
    for (int v = 0; v < 11; v++) begin
      busy_cnt = 0;
      n = vecs[v].n_inc + int'(vecs[v].both) + int'(vecs[v].clr);
      repeat (vecs[v].n_inc) pulse(1, 0);
      if (vecs[v].both) pulse(1, 1);
      if (vecs[v].clr) pulse(0, 1);
      w = 0;
      while (busy && w < 20) begin tick; w++; end
      chk("vec_timeout", {31'h0, busy}, 32'h0);
      chk("vec_addr", {28'h0, cur_addr}, {28'h0, vecs[v].exp_addr});
      chk("vec_ena", {16'h0, ena}, 32'h1 << vecs[v].exp_addr);
      chk("vec_guard", busy_cnt, 4 * n);
    end
    // Held sel_inc across a mid-operation reset must not cause a second step
    sel_inc = 1;
    repeat (10) tick;
    chk("hold_addr", {28'h0, cur_addr}, 32'd7);
    chk("hold_busy", {31'h0, busy}, 32'h0);
    rst_n = 0;
    tick;
    chk("mid_rst_addr", {28'h0, cur_addr}, 32'h0);
    chk("mid_rst_ena", {16'h0, ena}, 32'h0);
    chk("mid_rst_out", {8'h0, uio_oe, uio_out, uo_out}, 32'h0);
    rst_n = 1;
    repeat (10) tick;
    chk("post_rst_addr", {28'h0, cur_addr}, 32'h0);
    chk("post_rst_ena", {16'h0, ena}, 32'h1);
    sel_inc = 0;
    repeat (5) tick;
    chk("fall_addr", {28'h0, cur_addr}, 32'h0);
    // Second event lands with cnt==2: guard restarts from it
    sel_inc = 1; tick;
    sel_inc = 0; tick; tick;
    sel_inc = 1; tick;
    sel_inc = 0;
    chk("dbl_first", {27'h0, busy, cur_addr}, {27'h0, 1'b1, 4'd1});
    repeat (6) tick;
    chk("dbl_hold", {27'h0, busy, cur_addr}, {27'h0, 1'b1, 4'd2});
    chk("dbl_ena0", {16'h0, ena}, 32'h0);
    tick;
    chk("dbl_busy", {31'h0, busy}, 32'h0);
    chk("dbl_ena", {16'h0, ena}, 32'h4);
    repeat (3) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
